// File: rtl/de_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : de_pipe_reg_pkg
// Description : Shared constants and types for the Decode->Execute pipeline
//               register: MDU opcode encoding, exception handler entry PC,
//               Tuse encoding and the E-stage field bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package de_pipe_reg_pkg;

    // MDU opcodes. MDU_none marks an instruction that does not use the MDU.
    localparam logic [31:0] MDU_none  = 32'd0;
    localparam logic [31:0] MDU_mult  = 32'd1;
    localparam logic [31:0] MDU_multu = 32'd2;
    localparam logic [31:0] MDU_div   = 32'd3;
    localparam logic [31:0] MDU_divu  = 32'd4;
    localparam logic [31:0] MDU_mfhi  = 32'd5;
    localparam logic [31:0] MDU_mflo  = 32'd6;
    localparam logic [31:0] MDU_mthi  = 32'd7;
    localparam logic [31:0] MDU_mtlo  = 32'd8;

    // Exception handler entry loaded into E on a flush.
    localparam logic [31:0] C_HANDLER_PC = 32'h0000_4180;

    // Tuse of 3 means the operand is never read. Since Tnew never exceeds 2,
    // the Tnew > Tuse compare can never fire for an unused operand.
    localparam logic [1:0] C_TUSE_UNUSED = 2'd3;

    localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

    // All fields carried from D into E.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  wa;
        logic [1:0]  tnew;
        logic [31:0] mdu_op;
        logic        bd;
        logic [4:0]  exc_code;
    } e_fields_t;

    // Every MDU opcode, including the HI/LO moves, is MDU-class.
    function automatic logic is_mdu_class(input logic [31:0] op);
        return (op != MDU_none);
    endfunction

endpackage
`default_nettype wire

// File: rtl/de_pipe_reg_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : de_pipe_reg_hazard_detect
// Description : Purely combinational stall generation for the D stage.
//               Detects read-after-write hazards against the E and M stage
//               producers and MDU-class instructions issued while the MDU
//               is busy. A flush request suppresses the stall.
// Ports       : d_*_i      - D-stage source registers, Tuse, MDU opcode
//               e_*_i/m_*_i - E/M stage destination register and Tnew
//               e_mdu_busy_i - nonzero while the MDU is busy or starting
//               req_i      - flush request
//               stall_o    - freeze F/D
// Revision    : 1.0 - initial release
// ============================================================================
module de_pipe_reg_hazard_detect
    import de_pipe_reg_pkg::*;
(
    input  logic [4:0]  d_rs_addr_i,
    input  logic [4:0]  d_rt_addr_i,
    input  logic [1:0]  d_tuse_rs_i,
    input  logic [1:0]  d_tuse_rt_i,
    input  logic [31:0] d_mdu_op_i,
    input  logic [4:0]  e_wa_i,
    input  logic [1:0]  e_tnew_i,
    input  logic [4:0]  m_wa_i,
    input  logic [1:0]  m_tnew_i,
    input  logic [31:0] e_mdu_busy_i,
    input  logic        req_i,
    output logic        stall_o
);

    logic w_haz_rs;
    logic w_haz_rt;
    logic w_haz_mdu;

    // Register 0 is excluded up front, so a bubble (wa = 0) never matches.
    assign w_haz_rs = (d_rs_addr_i != 5'd0) &&
                      (((e_wa_i == d_rs_addr_i) && (e_tnew_i > d_tuse_rs_i)) ||
                       ((m_wa_i == d_rs_addr_i) && (m_tnew_i > d_tuse_rs_i)));

    assign w_haz_rt = (d_rt_addr_i != 5'd0) &&
                      (((e_wa_i == d_rt_addr_i) && (e_tnew_i > d_tuse_rt_i)) ||
                       ((m_wa_i == d_rt_addr_i) && (m_tnew_i > d_tuse_rt_i)));

    assign w_haz_mdu = is_mdu_class(d_mdu_op_i) && (e_mdu_busy_i != 32'd0);

    // Flush wins over any hazard.
    assign stall_o = (w_haz_rs | w_haz_rt | w_haz_mdu) & ~req_i;

endmodule
`default_nettype wire

// File: rtl/de_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : de_pipe_reg
// Description : Decode->Execute pipeline register with stall detection.
//               Latches D fields into E every cycle, inserts a PC-preserving
//               bubble on stall, flushes to the handler entry on Req, and
//               counts bubble cycles with a saturating counter.
// Ports       : clk, reset (sync, active-high), Req (flush)
//               d_*        - decoded D-stage fields
//               e_mdu_busy - MDU busy word; m_wa/m_tnew - M-stage producer
//               stall      - combinational freeze for F/D
//               e_*        - registered E-stage copies of the D fields
//               stall_cnt  - saturating bubble count
// Revision    : 1.0 - initial release
// ============================================================================
module de_pipe_reg
    import de_pipe_reg_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = C_HANDLER_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_rs_val,
    input  logic [31:0] d_rt_val,
    input  logic [4:0]  d_rs_addr,
    input  logic [4:0]  d_rt_addr,
    input  logic [4:0]  d_wa,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic [1:0]  d_tnew,
    input  logic [31:0] d_mdu_op,
    input  logic        d_bd,
    input  logic [4:0]  d_exc_code,
    input  logic [31:0] e_mdu_busy,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  m_tnew,
    output logic        stall,
    output logic [31:0] e_pc,
    output logic [31:0] e_instr,
    output logic [31:0] e_rs_val,
    output logic [31:0] e_rt_val,
    output logic [4:0]  e_rs_addr,
    output logic [4:0]  e_rt_addr,
    output logic [4:0]  e_wa,
    output logic [1:0]  e_tnew,
    output logic [31:0] e_mdu_op,
    output logic        e_bd,
    output logic [4:0]  e_exc_code,
    output logic [31:0] stall_cnt
);

    e_fields_t   e_q;
    e_fields_t   e_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic        w_stall;

    de_pipe_reg_hazard_detect u_hazard_detect (
        .d_rs_addr_i  (d_rs_addr),
        .d_rt_addr_i  (d_rt_addr),
        .d_tuse_rs_i  (d_tuse_rs),
        .d_tuse_rt_i  (d_tuse_rt),
        .d_mdu_op_i   (d_mdu_op),
        .e_wa_i       (e_q.wa),
        .e_tnew_i     (e_q.tnew),
        .m_wa_i       (m_wa),
        .m_tnew_i     (m_tnew),
        .e_mdu_busy_i (e_mdu_busy),
        .req_i        (Req),
        .stall_o      (w_stall)
    );

    always_comb begin
        e_d         = '0;
        stall_cnt_d = stall_cnt_q;
        if (Req) begin
            e_d.pc = HANDLER_PC;
        end else if (w_stall) begin
            // Bubble keeps PC and delay-slot flag so an exception taken on
            // the bubble still reports the stalled instruction's EPC. A zero
            // mdu_op guarantees the MDU is not started a second time.
            e_d.pc = d_pc;
            e_d.bd = d_bd;
            if (stall_cnt_q != C_CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end else begin
            e_d.pc       = d_pc;
            e_d.instr    = d_instr;
            e_d.rs_val   = d_rs_val;
            e_d.rt_val   = d_rt_val;
            e_d.rs_addr  = d_rs_addr;
            e_d.rt_addr  = d_rt_addr;
            e_d.wa       = d_wa;
            e_d.tnew     = d_tnew;
            e_d.mdu_op   = d_mdu_op;
            e_d.bd       = d_bd;
            e_d.exc_code = d_exc_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q         <= '0;
            stall_cnt_q <= 32'd0;
        end else begin
            e_q         <= e_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall      = w_stall;
    assign e_pc       = e_q.pc;
    assign e_instr    = e_q.instr;
    assign e_rs_val   = e_q.rs_val;
    assign e_rt_val   = e_q.rt_val;
    assign e_rs_addr  = e_q.rs_addr;
    assign e_rt_addr  = e_q.rt_addr;
    assign e_wa       = e_q.wa;
    assign e_tnew     = e_q.tnew;
    assign e_mdu_op   = e_q.mdu_op;
    assign e_bd       = e_q.bd;
    assign e_exc_code = e_q.exc_code;
    assign stall_cnt  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_de_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_de_pipe_reg
// Description : Directed self-checking bench for de_pipe_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_de_pipe_reg;

    logic        clk = 1'b0;
    logic        reset, Req;
    logic [31:0] d_pc, d_instr, d_rs_val, d_rt_val, d_mdu_op, e_mdu_busy;
    logic [4:0]  d_rs_addr, d_rt_addr, d_wa, d_exc_code, m_wa;
    logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew, m_tnew;
    logic        d_bd;
    logic        stall;
    logic [31:0] e_pc, e_instr, e_rs_val, e_rt_val, e_mdu_op, stall_cnt;
    logic [4:0]  e_rs_addr, e_rt_addr, e_wa, e_exc_code;
    logic [1:0]  e_tnew;
    logic        e_bd;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [31:0] C_MDU_DIV  = 32'd3;
    localparam logic [31:0] C_MDU_MFLO = 32'd6;
    localparam logic [31:0] C_MDU_MULT = 32'd1;

    de_pipe_reg #(.HANDLER_PC(32'h0000_4180)) dut (
        .clk(clk), .reset(reset), .Req(Req),
        .d_pc(d_pc), .d_instr(d_instr), .d_rs_val(d_rs_val), .d_rt_val(d_rt_val),
        .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr), .d_wa(d_wa),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_tnew(d_tnew),
        .d_mdu_op(d_mdu_op), .d_bd(d_bd), .d_exc_code(d_exc_code),
        .e_mdu_busy(e_mdu_busy), .m_wa(m_wa), .m_tnew(m_tnew),
        .stall(stall),
        .e_pc(e_pc), .e_instr(e_instr), .e_rs_val(e_rs_val), .e_rt_val(e_rt_val),
        .e_rs_addr(e_rs_addr), .e_rt_addr(e_rt_addr), .e_wa(e_wa), .e_tnew(e_tnew),
        .e_mdu_op(e_mdu_op), .e_bd(e_bd), .e_exc_code(e_exc_code),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle(input logic [31:0] pc);
        d_pc = pc; d_instr = 32'd0; d_rs_val = 32'd0; d_rt_val = 32'd0;
        d_rs_addr = 5'd0; d_rt_addr = 5'd0; d_wa = 5'd0;
        d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_tnew = 2'd0;
        d_mdu_op = 32'd0; d_bd = 1'b0; d_exc_code = 5'd0;
    endtask

    // lw r8: writes r8 with Tnew=2 at E.
    task automatic drive_lw(input logic [31:0] pc);
        drive_idle(pc);
        d_instr = 32'h8FA8_0000; d_rs_addr = 5'd29; d_tuse_rs = 2'd1;
        d_wa = 5'd8; d_tnew = 2'd2;
    endtask

    task automatic test_reset();
        reset = 1'b1; Req = 1'b0; e_mdu_busy = 32'd0; m_wa = 5'd0; m_tnew = 2'd0;
        drive_idle(32'h0000_3000);
        tick(); tick();
        total_cnt++; if (e_pc !== 32'd0) $display("FAIL reset_e_pc: got %h expected %h", e_pc, 32'd0); else pass_cnt++;
        total_cnt++; if (e_wa !== 5'd0) $display("FAIL reset_e_wa: got %h expected 0", e_wa); else pass_cnt++;
        total_cnt++; if (e_mdu_op !== 32'd0) $display("FAIL reset_e_mdu_op: got %h expected 0", e_mdu_op); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt: got %h expected 0", stall_cnt); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_straight();
        drive_idle(32'h0000_3000);
        d_instr = 32'h2128_0004; d_rs_addr = 5'd9; d_tuse_rs = 2'd1;
        d_wa = 5'd8; d_tnew = 2'd1; d_rs_val = 32'h1234_5678;
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL straight_stall: got %b expected 0", stall); else pass_cnt++;
        tick();
        total_cnt++; if (e_pc !== 32'h3000) $display("FAIL straight_e_pc: got %h expected %h", e_pc, 32'h3000); else pass_cnt++;
        total_cnt++; if (e_wa !== 5'd8) $display("FAIL straight_e_wa: got %h expected 8", e_wa); else pass_cnt++;
        total_cnt++; if (e_tnew !== 2'd1) $display("FAIL straight_e_tnew: got %h expected 1", e_tnew); else pass_cnt++;
        total_cnt++; if (e_rs_val !== 32'h1234_5678) $display("FAIL straight_e_rs_val: got %h expected 12345678", e_rs_val); else pass_cnt++;
        total_cnt++; if (e_instr !== 32'h2128_0004) $display("FAIL straight_e_instr: got %h expected 21280004", e_instr); else pass_cnt++;
        drive_idle(32'h0000_3004);
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL straight_stall2: got %b expected 0", stall); else pass_cnt++;
        tick();
    endtask

    task automatic test_load_use();
        drive_lw(32'h0000_3000);
        tick();
        drive_idle(32'h0000_3004);
        d_instr = 32'h0109_5020; d_rs_addr = 5'd8; d_tuse_rs = 2'd0;
        d_wa = 5'd9; d_tnew = 2'd1;
        #1;
        total_cnt++; if (stall !== 1'b1) $display("FAIL loaduse_stall_e: got %b expected 1", stall); else pass_cnt++;
        tick();
        total_cnt++; if (e_pc !== 32'h3004) $display("FAIL loaduse_bubble1_pc: got %h expected 3004", e_pc); else pass_cnt++;
        total_cnt++; if (e_wa !== 5'd0) $display("FAIL loaduse_bubble1_wa: got %h expected 0", e_wa); else pass_cnt++;
        total_cnt++; if (e_instr !== 32'd0) $display("FAIL loaduse_bubble1_instr: got %h expected 0", e_instr); else pass_cnt++;
        // lw has advanced to M with one cycle left.
        m_wa = 5'd8; m_tnew = 2'd1;
        #1;
        total_cnt++; if (stall !== 1'b1) $display("FAIL loaduse_stall_m: got %b expected 1", stall); else pass_cnt++;
        tick();
        total_cnt++; if (stall_cnt !== 32'd2) $display("FAIL loaduse_cnt: got %0d expected 2", stall_cnt); else pass_cnt++;
        total_cnt++; if (e_tnew !== 2'd0) $display("FAIL loaduse_bubble2_tnew: got %h expected 0", e_tnew); else pass_cnt++;
        m_wa = 5'd0; m_tnew = 2'd0;
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL loaduse_release: got %b expected 0", stall); else pass_cnt++;
        tick();
        total_cnt++; if (e_wa !== 5'd9) $display("FAIL loaduse_consumer_wa: got %h expected 9", e_wa); else pass_cnt++;
        total_cnt++; if (e_instr !== 32'h0109_5020) $display("FAIL loaduse_consumer_instr: got %h expected 01095020", e_instr); else pass_cnt++;
        drive_idle(32'h0000_3008);
        tick();
    endtask

    task automatic test_mdu_busy();
        int bad_stall;
        int bad_op;
        drive_idle(32'h0000_3100);
        d_instr = 32'h0085_001A; d_rs_addr = 5'd4; d_rt_addr = 5'd5;
        d_tuse_rs = 2'd1; d_tuse_rt = 2'd1; d_mdu_op = C_MDU_DIV;
        tick();
        total_cnt++; if (e_mdu_op !== C_MDU_DIV) $display("FAIL mdu_div_in_e: got %h expected %h", e_mdu_op, C_MDU_DIV); else pass_cnt++;
        drive_idle(32'h0000_3104);
        d_instr = 32'h0000_5012; d_mdu_op = C_MDU_MFLO; d_wa = 5'd10; d_tnew = 2'd1;
        bad_stall = 0; bad_op = 0;
        // Start bit for one cycle, then 10 busy cycles.
        for (int i = 0; i < 11; i++) begin
            e_mdu_busy = (i == 0) ? 32'h0000_0001 : 32'h8000_0000;
            #1;
            if (stall !== 1'b1) bad_stall++;
            tick();
            if (e_mdu_op !== 32'd0 || e_pc !== 32'h3104) bad_op++;
        end
        total_cnt++; if (bad_stall != 0) $display("FAIL mdu_stall_cycles: got %0d unstalled cycles expected 0", bad_stall); else pass_cnt++;
        total_cnt++; if (bad_op != 0) $display("FAIL mdu_bubble_op: got %0d bad bubbles expected 0", bad_op); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd13) $display("FAIL mdu_cnt: got %0d expected 13", stall_cnt); else pass_cnt++;
        e_mdu_busy = 32'd0;
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL mdu_release: got %b expected 0", stall); else pass_cnt++;
        tick();
        total_cnt++; if (e_mdu_op !== C_MDU_MFLO) $display("FAIL mdu_mflo_in_e: got %h expected %h", e_mdu_op, C_MDU_MFLO); else pass_cnt++;
        total_cnt++; if (e_wa !== 5'd10) $display("FAIL mdu_mflo_wa: got %h expected 0a", e_wa); else pass_cnt++;
        drive_idle(32'h0000_3108);
        tick();
    endtask

    task automatic test_reg_zero();
        drive_idle(32'h0000_3200);
        d_wa = 5'd0; d_tnew = 2'd2;
        tick();
        drive_idle(32'h0000_3204);
        d_rs_addr = 5'd0; d_tuse_rs = 2'd0; d_rt_addr = 5'd0; d_tuse_rt = 2'd0;
        m_wa = 5'd0; m_tnew = 2'd2;
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL regzero_stall: got %b expected 0", stall); else pass_cnt++;
        m_tnew = 2'd0;
        tick();
    endtask

    task automatic test_req_flush();
        drive_lw(32'h0000_3300);
        tick();
        drive_idle(32'h0000_3304);
        d_instr = 32'h0109_0018; d_rs_addr = 5'd8; d_tuse_rs = 2'd0;
        d_wa = 5'd9; d_tnew = 2'd1; d_mdu_op = C_MDU_MULT; d_bd = 1'b1;
        d_exc_code = 5'd5; d_rs_val = 32'hDEAD_BEEF;
        #1;
        total_cnt++; if (stall !== 1'b1) $display("FAIL req_pre_stall: got %b expected 1", stall); else pass_cnt++;
        Req = 1'b1;
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL req_stall_suppressed: got %b expected 0", stall); else pass_cnt++;
        tick();
        Req = 1'b0;
        total_cnt++; if (e_pc !== 32'h0000_4180) $display("FAIL req_e_pc: got %h expected 00004180", e_pc); else pass_cnt++;
        total_cnt++; if ({e_instr, e_rs_val, e_rt_val, e_mdu_op} !== 128'd0) $display("FAIL req_e_words: got %h expected 0", {e_instr, e_rs_val, e_rt_val, e_mdu_op}); else pass_cnt++;
        total_cnt++; if ({e_rs_addr, e_rt_addr, e_wa, e_tnew, e_bd, e_exc_code} !== 23'd0) $display("FAIL req_e_fields: got %h expected 0", {e_rs_addr, e_rt_addr, e_wa, e_tnew, e_bd, e_exc_code}); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd13) $display("FAIL req_cnt: got %0d expected 13", stall_cnt); else pass_cnt++;
        drive_idle(32'h0000_4180);
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drive_lw(32'h0000_3400);
        tick();
        drive_idle(32'h0000_3404);
        d_rs_addr = 5'd8; d_tuse_rs = 2'd0; d_wa = 5'd9; d_tnew = 2'd1; d_bd = 1'b1;
        tick();
        total_cnt++; if (e_pc !== 32'h3404) $display("FAIL rststall_bubble_pc: got %h expected 3404", e_pc); else pass_cnt++;
        total_cnt++; if (e_bd !== 1'b1) $display("FAIL rststall_bubble_bd: got %b expected 1", e_bd); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd14) $display("FAIL rststall_cnt_pre: got %0d expected 14", stall_cnt); else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++; if ({e_pc, e_bd, e_wa} !== 38'd0) $display("FAIL rststall_e_nop: got %h expected 0", {e_pc, e_bd, e_wa}); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd0) $display("FAIL rststall_cnt: got %0d expected 0", stall_cnt); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL rststall_reeval: got %b expected 0", stall); else pass_cnt++;
    endtask

    task automatic test_saturation();
        drive_lw(32'h0000_3500);
        tick();
        dut.stall_cnt_q = 32'hFFFF_FFFF;
        drive_idle(32'h0000_3504);
        d_rs_addr = 5'd8; d_tuse_rs = 2'd0;
        #1;
        total_cnt++; if (stall !== 1'b1) $display("FAIL sat_stall: got %b expected 1", stall); else pass_cnt++;
        tick();
        total_cnt++; if (stall_cnt !== 32'hFFFF_FFFF) $display("FAIL sat_cnt: got %h expected ffffffff", stall_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_straight();
        test_load_use();
        test_mdu_busy();
        test_reg_zero();
        test_req_flush();
        test_reset_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/de_pipe_reg.md
# de_pipe_reg

Decode→Execute pipeline register with integrated stall detection for the five-stage MIPS core. It latches decoded D-stage fields into E every cycle. It raises `stall` for register read-after-write hazards and for MDU-class instructions while the E-stage MDU is busy, inserting a PC-preserving bubble. It flushes to the exception handler entry on `Req`.

## Interface
Parameters:
- `HANDLER_PC`, 32'h0000_4180: PC loaded into E on flush.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `Req` in 1: interrupt/exception request; flush.
- `d_pc`, `d_instr`, `d_rs_val`, `d_rt_val` in 32 each: D-stage PC, instruction, and forwarded operand values.
- `d_rs_addr`, `d_rt_addr`, `d_wa` in 5 each: source registers and destination register (0 = none).
- `d_tuse_rs`, `d_tuse_rt` in 2 each: cycles until each operand is needed; 3 = unused.
- `d_tnew` in 2: cycles until the result is ready, measured at E.
- `d_mdu_op` in 32: MDU opcode; `MDU_none` means not an MDU instruction.
- `d_bd` in 1: branch-delay-slot flag.
- `d_exc_code` in 5: exception code.
- `e_mdu_busy` in 32: MDU Busy word; nonzero means busy or starting.
- `m_wa` in 5, `m_tnew` in 2: M-stage destination and remaining Tnew.
- `stall` out 1: freeze F/D registers (combinational).
- `e_pc`, `e_instr`, `e_rs_val`, `e_rt_val`, `e_rs_addr`, `e_rt_addr`, `e_wa`, `e_tnew`, `e_mdu_op`, `e_bd`, `e_exc_code` out: registered copies, same widths as the D inputs.
- `stall_cnt` out 32: count of bubble cycles, saturating.

## Operation
Hazard terms (combinational):
- `haz_rs` = `d_rs_addr`≠0 && ((`e_wa`==`d_rs_addr` && `e_tnew`>`d_tuse_rs`) || (`m_wa`==`d_rs_addr` && `m_tnew`>`d_tuse_rs`)).
- `haz_rt`: same form on `d_rt_addr` / `d_tuse_rt`.
- `haz_mdu` = `d_mdu_op`≠`MDU_none` && `e_mdu_busy`≠0.
- `stall` = (`haz_rs`|`haz_rt`|`haz_mdu`) & ~`Req`.

Register update at posedge, in priority order:
1. `reset`: all E outputs 0 (nop, `e_mdu_op`=`MDU_none`=0, `e_pc`=0). `stall_cnt`=0.
2. `Req`: flush. `e_pc`=`HANDLER_PC`; all other E fields 0. `stall_cnt` unchanged.
3. `stall`: bubble. `e_pc`=`d_pc`, `e_bd`=`d_bd`; all other fields 0, so `e_wa`=0, `e_tnew`=0, `e_mdu_op`=`MDU_none`. `stall_cnt`+=1, saturating at 32'hFFFF_FFFF.
4. Otherwise: every E field takes its D input.

Rules:
- `e_wa`=0 never creates a hazard, because register 0 is excluded by the addr≠0 term.
- mthi, mtlo, mfhi and mflo count as MDU-class and stall while the MDU is busy.
- `Req` together with a hazard: flush wins and `stall` is 0 in that cycle.
- Because a bubble has `e_mdu_op`=`MDU_none`, the MDU never starts twice.

## Timing
- Zero-latency combinational path from D inputs to `stall`; one-cycle register latency from D to E.
- Multiply: a dependent MDU-class instruction in D stalls for the cycle the mult is in E (start bit) plus 5 busy cycles, so it enters E 6 cycles later.
- Divide: same pattern gives 11 stall cycles.
- RAW stall: a lw in E (`e_tnew`=2) with consumer `d_tuse_rs`=0 gives 2 stall cycles. The first is the E compare; the second is the M compare with `m_tnew`=1.
- Reset during a stall: the next cycle E holds nop, `stall_cnt`=0, and `stall` is re-evaluated from the inputs.

## Structure
- Shared constants header: `MDU_*` opcodes including `MDU_none`=0, `HANDLER_PC`, and the Tuse encoding where 3 means unused.
- One natural sub-module: `hazard_detect`, purely combinational, producing `stall`. The parent contains only the registers and the counter.

## Test plan
- Straight-line flow: `d_pc`=0x3000, `d_wa`=8, `d_tnew`=1 → next cycle `e_pc`=0x3000, `e_wa`=8; `stall`=0 throughout.
- Load-use: lw r8 in E with `e_tnew`=2, then `d_rs_addr`=8, `d_tuse_rs`=0 → `stall`=1 for 2 cycles; `e_pc` during the bubbles = consumer PC; `e_wa`=0; `stall_cnt`=2.
- MDU busy: issue div, then mflo in D → `stall` asserted for 11 cycles and `e_mdu_op` stays `MDU_none` during them; mflo reaches E on the 12th cycle.
- Register 0: `d_rs_addr`=0 with `e_wa`=0 and `e_tnew`=2 → no stall.
- Req during a hazard stall: `Req`=1 → `stall`=0; next cycle `e_pc`=0x4180 and all other E fields 0.
- Reset mid-stall: assert `reset` for 1 cycle → all E outputs 0 and `stall_cnt`=0; saturation check with the counter preset to 32'hFFFF_FFFF and a stall → counter stays 32'hFFFF_FFFF.
